// File: rtl/store_aligner.sv
// store_aligner: SB/SH/SW byte-lane alignment, misaligned stores split in two word writes.
// Define STORE_ALIGNER_MISALIGN_TRAP_EN to reject two-beat stores with err instead.
module store_aligner #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_funct3,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR_LO = 2'd1;
  localparam logic [1:0] S_WR_HI = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int WW = ADDR_WIDTH - 2;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [3:0]    lo_be_q, lo_be_d;
  logic [3:0]    hi_be_q, hi_be_d;
  logic [31:0]   lo_data_q, lo_data_d;
  logic [31:0]   hi_data_q, hi_data_d;
  logic          err_q, err_d;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] dsel;
  logic        legal;
  logic [7:0]  be_wide;
  logic [63:0] data_wide;
  logic        two_beat;

  assign off = req_addr[1:0];

  always_comb begin
    mask  = 4'b0000;
    dsel  = '0;
    legal = 1'b0;
    unique case (1'b1)
      (req_funct3 == 3'b000): begin
        mask  = 4'b0001;
        dsel  = {24'b0, req_data[7:0]};
        legal = 1'b1;
      end
      (req_funct3 == 3'b001): begin
        mask  = 4'b0011;
        dsel  = {16'b0, req_data[15:0]};
        legal = 1'b1;
      end
      (req_funct3 == 3'b010): begin
        mask  = 4'b1111;
        dsel  = req_data;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

  // Shifting into a double word yields both beats; the upper half is the hi beat.
  assign be_wide   = {4'b0000, mask} << off;
  assign data_wide = {32'b0, dsel} << {off, 3'b000};
  assign two_beat  = |be_wide[7:4];

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    lo_be_d   = lo_be_q;
    hi_be_d   = hi_be_q;
    lo_data_d = lo_data_q;
    hi_data_d = hi_data_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            err_d = 1'b1;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
          end else if (two_beat) begin
            err_d = 1'b1;
`endif
          end else begin
            state_d   = S_WR_LO;
            word_d    = req_addr[ADDR_WIDTH-1:2];
            lo_be_d   = be_wide[3:0];
            hi_be_d   = be_wide[7:4];
            lo_data_d = data_wide[31:0];
            hi_data_d = data_wide[63:32];
          end
        end
      end
      S_WR_LO: begin
        if (mem_ready) begin
          state_d = (hi_be_q != 4'b0000) ? S_WR_HI : S_DONE;
        end
      end
      S_WR_HI: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      lo_be_q   <= '0;
      hi_be_q   <= '0;
      lo_data_q <= '0;
      hi_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      lo_be_q   <= lo_be_d;
      hi_be_q   <= hi_be_d;
      lo_data_q <= lo_data_d;
      hi_data_q <= hi_data_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_we    = (state_q == S_WR_LO) || (state_q == S_WR_HI);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

  always_comb begin
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if (state_q == S_WR_LO) begin
      mem_addr  = {word_q, 2'b00};
      mem_be    = lo_be_q;
      mem_wdata = lo_data_q;
    end else if (state_q == S_WR_HI) begin
      mem_addr  = {word_q + {{(WW-1){1'b0}}, 1'b1}, 2'b00};
      mem_be    = hi_be_q;
      mem_wdata = hi_data_q;
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// tb_store_aligner: directed and randomized checks of store_aligner
// against a byte-level reference model.
module tb_store_aligner;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_funct3;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        done;
  logic        err;

  int checks = 0;
  int fails  = 0;

  logic [31:0] obs_addr[$];
  logic [3:0]  obs_be[$];
  logic [31:0] obs_data[$];
  int          obs_done_cyc;
  int          obs_err_cyc;
  int          obs_rdy_bad;
  int          obs_be_bad;
  int          obs_we_cnt;
  logic        obs_timeout;
  logic        obs_rdy_after;
  logic        obs_extra;

  logic [31:0] exp_addr[$];
  logic [3:0]  exp_be[$];
  logic [31:0] exp_data[$];
  logic        exp_err;

  store_aligner #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_funct3 (req_funct3),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Every byte of the store goes to address a+i; group bytes by word.
  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f);
    int n;
    int k;
    int lane;
    logic [31:0] w0;
    logic [31:0] ba;
    logic [3:0]  be [2];
    logic [31:0] dat [2];
    exp_addr.delete();
    exp_be.delete();
    exp_data.delete();
    exp_err = 1'b0;
    be[0] = 4'b0; be[1] = 4'b0;
    dat[0] = 32'b0; dat[1] = 32'b0;
    n = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
    if (n == 0) begin
      exp_err = 1'b1;
      return;
    end
    w0 = a >> 2;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      k = ((ba >> 2) == w0) ? 0 : 1;
      lane = int'(ba[1:0]);
      be[k][lane] = 1'b1;
      dat[k][8*lane +: 8] = d[8*i +: 8];
    end
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
    if (be[1] != 4'b0) begin
      exp_err = 1'b1;
      return;
    end
`endif
    for (int j = 0; j < 2; j++) begin
      if (be[j] != 4'b0) begin
        exp_addr.push_back((w0 + 32'(j)) << 2);
        exp_be.push_back(be[j]);
        exp_data.push_back(dat[j]);
      end
    end
  endfunction

  // Issue one request and record what the memory side accepts, cycle by cycle.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input int stall_pct);
    int cyc;
    obs_addr.delete();
    obs_be.delete();
    obs_data.delete();
    obs_done_cyc = -1;
    obs_err_cyc  = -1;
    obs_rdy_bad  = 0;
    obs_be_bad   = 0;
    obs_we_cnt   = 0;
    req_valid  = 1'b1;
    req_addr   = a;
    req_data   = d;
    req_funct3 = f;
    mem_ready  = 1'b0;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_data   = $urandom;
    req_funct3 = 3'($urandom);
    cyc = 1;
    while (obs_done_cyc < 0 && obs_err_cyc < 0 && cyc < 60) begin
      mem_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (mem_we) obs_we_cnt++;
      if (mem_we && mem_ready) begin
        obs_addr.push_back(mem_addr);
        obs_be.push_back(mem_be);
        obs_data.push_back(mem_wdata);
      end
      if (!mem_we && mem_be != 4'b0) obs_be_bad++;
      if ((mem_we || done) && req_ready) obs_rdy_bad++;
      if (done) obs_done_cyc = cyc;
      if (err) obs_err_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    obs_timeout = (obs_done_cyc < 0 && obs_err_cyc < 0);
    mem_ready = 1'b0;
    @(negedge clk);
    obs_rdy_after = req_ready;
    obs_extra = mem_we | done | err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_funct3 = '0;
    mem_ready = 1'b0;
    #2;
    checks++;
    if ({req_ready, mem_we, mem_be, done, err} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 10000000",
               {req_ready, mem_we, mem_be, done, err});
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_req(32'h1002, 32'hAABBCC5A, 3'b000, 0);
    checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000 ||
        obs_be[0] !== 4'b0100 || obs_data[0] !== 32'h005A0000) begin
      fails++;
      $display("FAIL sb_beat: got n=%0d addr=%h be=%b data=%h expected n=1 1000 0100 005a0000",
               obs_addr.size(), obs_addr[0], obs_be[0], obs_data[0]);
    end
    checks++;
    if (obs_done_cyc != 2 || obs_rdy_after !== 1'b1) begin
      fails++;
      $display("FAIL sb_latency: got done_cyc=%0d rdy=%b expected 2 1",
               obs_done_cyc, obs_rdy_after);
    end

    run_req(32'h2001, 32'h0000BEEF, 3'b001, 0);
    checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 32'h2000 ||
        obs_be[0] !== 4'b0110 || obs_data[0] !== 32'h00BEEF00) begin
      fails++;
      $display("FAIL sh_beat: got n=%0d addr=%h be=%b data=%h expected n=1 2000 0110 00beef00",
               obs_addr.size(), obs_addr[0], obs_be[0], obs_data[0]);
    end

    run_req(32'h3003, 32'h11223344, 3'b010, 0);
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
    checks++;
    if (obs_we_cnt != 0 || obs_err_cyc != 1) begin
      fails++;
      $display("FAIL sw_trap: got we_cnt=%0d err_cyc=%0d expected 0 1",
               obs_we_cnt, obs_err_cyc);
    end
`else
    checks++;
    if (obs_addr.size() != 2) begin
      fails++;
      $display("FAIL sw_split_n: got %0d expected 2", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 32'h3000 || obs_be[0] !== 4'b1000 ||
          obs_data[0] !== 32'h44000000) begin
        fails++;
        $display("FAIL sw_split_lo: got %h %b %h expected 3000 1000 44000000",
                 obs_addr[0], obs_be[0], obs_data[0]);
      end
      checks++;
      if (obs_addr[1] !== 32'h3004 || obs_be[1] !== 4'b0111 ||
          obs_data[1] !== 32'h00112233) begin
        fails++;
        $display("FAIL sw_split_hi: got %h %b %h expected 3004 0111 00112233",
                 obs_addr[1], obs_be[1], obs_data[1]);
      end
    end
    checks++;
    if (obs_done_cyc != 3) begin
      fails++;
      $display("FAIL sw_split_lat: got done_cyc=%0d expected 3", obs_done_cyc);
    end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] d;
    d = $urandom;
    req_valid  = 1'b1;
    req_addr   = 32'h4000;
    req_data   = d;
    req_funct3 = 3'b010;
    mem_ready  = 1'b0;
    @(posedge clk); #1;
    req_addr   = 32'h7777;
    req_funct3 = 3'b111;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_we, req_ready, done, err} !== 4'b1000) begin
        fails++;
        $display("FAIL stall_ctrl: cyc %0d got we/rdy/done/err=%b expected 1000",
                 c, {mem_we, req_ready, done, err});
      end
      checks++;
      if (mem_addr !== 32'h4000 || mem_be !== 4'hF || mem_wdata !== d) begin
        fails++;
        $display("FAIL stall_hold: cyc %0d got %h %b %h expected 4000 1111 %h",
                 c, mem_addr, mem_be, mem_wdata, d);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, mem_we, mem_be} !== 6'b100000) begin
      fails++;
      $display("FAIL stall_done: got done/we/be=%b expected 100000",
               {done, mem_we, mem_be});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({req_ready, done, err} !== 3'b100) begin
      fails++;
      $display("FAIL stall_idle: got rdy/done/err=%b expected 100",
               {req_ready, done, err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    run_req(32'h5000, $urandom, 3'b011, 0);
    checks++;
    if (obs_err_cyc != 1 || obs_we_cnt != 0) begin
      fails++;
      $display("FAIL illegal_err: got err_cyc=%0d we_cnt=%0d expected 1 0",
               obs_err_cyc, obs_we_cnt);
    end
    checks++;
    if (obs_rdy_after !== 1'b1 || obs_extra !== 1'b0) begin
      fails++;
      $display("FAIL illegal_after: got rdy=%b extra=%b expected 1 0",
               obs_rdy_after, obs_extra);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    for (int it = 0; it < 60; it++) begin
      a = $urandom;
      if ($urandom_range(7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(3));
      d = $urandom;
      f = ($urandom_range(9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(2));
      model(a, d, f);
      run_req(a, d, f, 40);
      checks++;
      if (obs_timeout) begin
        fails++;
        $display("FAIL rnd_timeout: it %0d addr=%h f=%b no done/err", it, a, f);
      end
      checks++;
      if ((obs_err_cyc >= 0) !== exp_err) begin
        fails++;
        $display("FAIL rnd_err: it %0d addr=%h f=%b got err=%b expected %b",
                 it, a, f, obs_err_cyc >= 0, exp_err);
      end
      checks++;
      if (obs_addr.size() != exp_addr.size()) begin
        fails++;
        $display("FAIL rnd_nbeats: it %0d addr=%h f=%b got %0d expected %0d",
                 it, a, f, obs_addr.size(), exp_addr.size());
      end else begin
        for (int b = 0; b < exp_addr.size(); b++) begin
          checks++;
          if (obs_addr[b] !== exp_addr[b] || obs_be[b] !== exp_be[b] ||
              obs_data[b] !== exp_data[b]) begin
            fails++;
            $display("FAIL rnd_beat: it %0d beat %0d got %h %b %h expected %h %b %h",
                     it, b, obs_addr[b], obs_be[b], obs_data[b],
                     exp_addr[b], exp_be[b], exp_data[b]);
          end
        end
      end
      checks++;
      if (obs_rdy_bad != 0 || obs_be_bad != 0 || obs_rdy_after !== 1'b1 ||
          obs_extra !== 1'b0) begin
        fails++;
        $display("FAIL rnd_hshake: it %0d rdy_bad=%0d be_bad=%0d rdy_after=%b extra=%b",
                 it, obs_rdy_bad, obs_be_bad, obs_rdy_after, obs_extra);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid  = 1'b1;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
    req_addr   = 32'h3000;
`else
    req_addr   = 32'h3003;
`endif
    req_data   = 32'h11223344;
    req_funct3 = 3'b010;
    mem_ready  = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
`ifndef STORE_ALIGNER_MISALIGN_TRAP_EN
    @(posedge clk); #1;
`endif
    checks++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: got mem_we=%b expected 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_we, mem_be, done, err} !== 8'b1000_0000 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_out: got ctrl=%b addr=%h wdata=%h expected 10000000 0 0",
               {req_ready, mem_we, mem_be, done, err}, mem_addr, mem_wdata);
    end
    mem_ready = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    model(32'h2002, 32'hCAFEF00D, 3'b001);
    run_req(32'h2002, 32'hCAFEF00D, 3'b001, 0);
    checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] ||
        obs_be[0] !== exp_be[0] || obs_data[0] !== exp_data[0] ||
        obs_done_cyc != 2) begin
      fails++;
      $display("FAIL rstmid_next: got n=%0d %h %b %h done_cyc=%0d expected 1 %h %b %h 2",
               obs_addr.size(), obs_addr[0], obs_be[0], obs_data[0], obs_done_cyc,
               exp_addr[0], exp_be[0], exp_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
